// File: rtl/pc_seq_pkg.sv
// Shared types for the next-PC sequencer: FSM states and redirect selections.
package pc_seq_pkg;

    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED,
        FAULT
    } seq_state_t;

    typedef enum logic [2:0] {
        HOLD,
        INC,
        BRANCH,
        JUMP,
        CALL,
        RET
    } redirect_t;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address LIFO. Overflow/underflow are policed by the caller; requests
// that would overflow or underflow are ignored here.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      cnt;
    logic [PW-1:0]    top_idx;

    assign top_idx = cnt[PW-1:0] - 1'b1;
    assign top     = mem[top_idx];
    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);

    // Entry count and storage; clearing only resets the count, stale data is unreachable.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (push && !full) begin
            mem[cnt[PW-1:0]] <= push_data;
            cnt              <= cnt + 1'b1;
        end else if (pop && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: chooses hold/increment/branch/jump/call/return, drives the
// PC register's load pins, runs the fetch handshake and owns the return stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              ADDR_W    = ADDR_W_DEF,
    parameter int              RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic              fetch_ack,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] pc_q,
    output logic              pc_load_en,
    output logic [ADDR_W-1:0] pc_d,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              halted,
    output logic              fault
);
    seq_state_t        state, next_state;
    redirect_t         sel;
    logic              fault_ev;
    logic              ras_full, ras_empty;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] ret_addr;

    assign ret_addr   = pc_q + 1'b1;
    assign fetch_req  = (state == RUN);
    assign fetch_addr = pc_q;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (sel == CALL),
        .pop       (sel == RET),
        .push_data (ret_addr),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // Redirect priority and next state; a stack fault suppresses the redirect and holds the PC.
    always_comb begin
        sel        = HOLD;
        fault_ev   = 1'b0;
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                if (fetch_ack) begin
                    if (ret) begin
                        if (ras_empty) fault_ev = 1'b1;
                        else           sel      = RET;
                    end else if (call) begin
                        if (ras_full)  fault_ev = 1'b1;
                        else           sel      = CALL;
                    end else if (jump) begin
                        sel = JUMP;
                    end else if (branch_taken) begin
                        sel = BRANCH;
                    end else begin
                        sel = INC;
                    end
                end
                if (fault_ev)      next_state = FAULT;
                else if (halt_req) next_state = HALTED;
            end
            HALTED: begin
                if (start && !halt_req) next_state = RUN;
            end
            default: next_state = FAULT;
        endcase
    end

    // PC load pins; IDLE and reset pin the PC to the reset vector.
    always_comb begin
        pc_load_en = 1'b1;
        pc_d       = pc_q;
        if (reset || state == IDLE) begin
            pc_d = RESET_VEC;
        end else begin
            case (sel)
                INC:          pc_load_en = 1'b0;
                RET:          pc_d = ras_top;
                CALL, JUMP:   pc_d = jump_target;
                BRANCH:       pc_d = branch_target;
                default:      pc_d = pc_q;
            endcase
        end
    end

    // State register with registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else begin
            state  <= next_state;
            halted <= (next_state == HALTED);
            fault  <= (next_state == FAULT);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer driving a simple PC register.
module tb_pc_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       halt_req;
    logic       fetch_ack;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       jump;
    logic [7:0] jump_target;
    logic       call;
    logic       ret;
    logic [7:0] pc_q;
    logic       pc_load_en;
    logic [7:0] pc_d;
    logic       fetch_req;
    logic [7:0] fetch_addr;
    logic       halted;
    logic       fault;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .ADDR_W    (8),
        .RAS_DEPTH (4),
        .RESET_VEC (8'h00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .halt_req      (halt_req),
        .fetch_ack     (fetch_ack),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .call          (call),
        .ret           (ret),
        .pc_q          (pc_q),
        .pc_load_en    (pc_load_en),
        .pc_d          (pc_d),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .halted        (halted),
        .fault         (fault)
    );

    // PC register: self-increments unless loaded.
    always_ff @(posedge clk) begin
        if (reset)           pc_q <= 8'h00;
        else if (pc_load_en) pc_q <= pc_d;
        else                 pc_q <= pc_q + 8'd1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; halt_req = 1'b0; fetch_ack = 1'b0;
        branch_taken = 1'b0; branch_target = 8'h00; jump = 1'b0;
        jump_target = 8'h00; call = 1'b0; ret = 1'b0;

        // Reset state
        tick();
        check("rst_pc", pc_q, 8'h00);
        check("rst_halted", halted, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_freq", fetch_req, 1'b0);
        check("rst_lden", pc_load_en, 1'b1);
        check("rst_d", pc_d, 8'h00);
        reset = 1'b0;
        settle();
        check("idle_lden", pc_load_en, 1'b1);
        check("idle_freq", fetch_req, 1'b0);

        // 1. Sequential fetch
        start = 1'b1;
        tick();
        start = 1'b0;
        fetch_ack = 1'b1;
        settle();
        check("seq_freq", fetch_req, 1'b1);
        check("seq_addr0", fetch_addr, 8'h00);
        check("seq_lden0", pc_load_en, 1'b0);
        tick();
        check("seq_addr1", fetch_addr, 8'h01);
        check("seq_lden1", pc_load_en, 1'b0);
        tick();
        check("seq_addr2", fetch_addr, 8'h02);
        tick();
        check("seq_addr3", fetch_addr, 8'h03);

        // 2. Stall at PC=5
        tick();
        tick();
        check("stall_pre", pc_q, 8'h05);
        fetch_ack = 1'b0;
        branch_taken = 1'b1; branch_target = 8'h99;
        settle();
        check("stall_lden", pc_load_en, 1'b1);
        check("stall_d", pc_d, 8'h05);
        tick();
        check("stall_pc1", pc_q, 8'h05);
        tick();
        check("stall_pc2", pc_q, 8'h05);
        branch_taken = 1'b0;
        fetch_ack = 1'b1;
        tick();
        check("stall_ack", pc_q, 8'h06);

        // 3. Jump beats branch; wrap at 0xFF
        jump = 1'b1; jump_target = 8'h10;
        tick();
        check("jmp_10", pc_q, 8'h10);
        jump_target = 8'h40; branch_taken = 1'b1; branch_target = 8'h55;
        settle();
        check("prio_d", pc_d, 8'h40);
        tick();
        check("prio_pc", pc_q, 8'h40);
        branch_taken = 1'b0; jump_target = 8'hFF;
        tick();
        check("jmp_ff", pc_q, 8'hFF);
        jump = 1'b0;
        tick();
        check("wrap", pc_q, 8'h00);

        // 4. Call / return, then underflow
        jump = 1'b1; jump_target = 8'h20;
        tick();
        jump = 1'b0; call = 1'b1; jump_target = 8'h80;
        tick();
        check("call_pc", pc_q, 8'h80);
        call = 1'b0; ret = 1'b1;
        settle();
        check("ret_d", pc_d, 8'h21);
        tick();
        check("ret_pc", pc_q, 8'h21);
        settle();
        check("uflow_lden", pc_load_en, 1'b1);
        check("uflow_d", pc_d, 8'h21);
        tick();
        check("uflow_fault", fault, 1'b1);
        check("uflow_pc", pc_q, 8'h21);
        check("uflow_freq", fetch_req, 1'b0);
        ret = 1'b0; start = 1'b1;
        tick();
        tick();
        check("fault_sticky", fault, 1'b1);
        check("fault_pc", pc_q, 8'h21);
        check("fault_freq", fetch_req, 1'b0);
        start = 1'b0;

        // 5. Overflow on fifth nested call
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("clr_fault", fault, 1'b0);
        check("clr_pc", pc_q, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        call = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            jump_target = 8'(i * 16);
            tick();
            check("ncall_pc", pc_q, 8'(i * 16));
            check("ncall_fault", fault, 1'b0);
        end
        jump_target = 8'h50;
        settle();
        check("oflow_d", pc_d, 8'h40);
        tick();
        check("oflow_fault", fault, 1'b1);
        check("oflow_pc", pc_q, 8'h40);
        call = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("frst_fault", fault, 1'b0);
        check("frst_pc", pc_q, 8'h00);
        check("frst_freq", fetch_req, 1'b0);
        check("frst_halted", halted, 1'b0);

        // 6. Halt with same-cycle branch, then resume
        start = 1'b1;
        tick();
        start = 1'b0;
        branch_taken = 1'b1; branch_target = 8'h30; halt_req = 1'b1;
        tick();
        check("halt_pc", pc_q, 8'h30);
        check("halt_flag", halted, 1'b1);
        check("halt_freq", fetch_req, 1'b0);
        branch_taken = 1'b0; halt_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_hold", pc_q, 8'h30);
            check("halt_stay", halted, 1'b1);
        end
        start = 1'b1; halt_req = 1'b1;
        tick();
        check("halt_both", halted, 1'b1);
        check("halt_both_pc", pc_q, 8'h30);
        halt_req = 1'b0;
        tick();
        start = 1'b0;
        check("resume_halted", halted, 1'b0);
        check("resume_freq", fetch_req, 1'b1);
        check("resume_addr", fetch_addr, 8'h30);
        tick();
        check("resume_inc", pc_q, 8'h31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
